// File: rtl/register_bank_sb.sv
// Parametrised register file with a write-back scoreboard and operand-hazard stall outputs.
// Optional same-cycle write-back forwarding to the read ports is enabled by REGFILE_BYPASS_EN.
module register_bank_sb #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(NREGS)-1:0] rs1,
    input  logic [$clog2(NREGS)-1:0] rs2,
    output logic [XLEN-1:0]          rs1_value,
    output logic [XLEN-1:0]          rs2_value,
    input  logic                     reg_write,
    input  logic [$clog2(NREGS)-1:0] rd,
    input  logic [XLEN-1:0]          rd_value,
    input  logic                     issue_valid,
    input  logic [$clog2(NREGS)-1:0] issue_rd,
    output logic                     rs1_busy,
    output logic                     rs2_busy,
    output logic                     stall,
    output logic                     waw_err
);

    localparam int unsigned AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] pending_q, pending_d;
    logic             waw_q, waw_d;
    logic             wr_en, iss_en;
    logic             byp1, byp2;

    assign wr_en  = reg_write && (rd != '0);
    assign iss_en = issue_valid && (issue_rd != '0);

    // Clear on write-back first so a same-index issue in the same cycle keeps the bit set.
    always_comb begin
        pending_d = pending_q;
        if (wr_en) begin
            pending_d[rd] = 1'b0;
        end
        if (iss_en) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    assign waw_d = iss_en && pending_q[issue_rd] && !(reg_write && (rd == issue_rd));

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q    <= '{default: '0};
            pending_q <= '0;
            waw_q     <= 1'b0;
        end else begin
            if (wr_en) begin
                regs_q[rd] <= rd_value;
            end
            pending_q <= pending_d;
            waw_q     <= waw_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign byp1 = wr_en && (rd == rs1);
    assign byp2 = wr_en && (rd == rs2);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    always_comb begin
        rs1_value = '0;
        rs2_value = '0;
        if (rs1 != '0) begin
            rs1_value = byp1 ? rd_value : regs_q[rs1];
        end
        if (rs2 != '0) begin
            rs2_value = byp2 ? rd_value : regs_q[rs2];
        end
    end

    // pending_q[0] is held at 0, so index 0 is never busy.
    assign rs1_busy = pending_q[rs1] && !byp1;
    assign rs2_busy = pending_q[rs2] && !byp2;
    assign stall    = rs1_busy || rs2_busy;
    assign waw_err  = waw_q;

    logic [AW-1:0] unused_aw;
    assign unused_aw = '0;

endmodule

// File: tb/tb_register_bank_sb.sv
// Directed self-checking bench for register_bank_sb: default 32x32 instance plus a 64-bit x 16 instance.
module tb_register_bank_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1, rs2, rd, issue_rd;
    logic [31:0] rs1_value, rs2_value, rd_value;
    logic        reg_write, issue_valid;
    logic        rs1_busy, rs2_busy, stall, waw_err;

    logic [3:0]  w_rs1, w_rs2, w_rd, w_issue_rd;
    logic [63:0] w_rs1_value, w_rs2_value, w_rd_value;
    logic        w_reg_write, w_issue_valid;
    logic        w_rs1_busy, w_rs2_busy, w_stall, w_waw_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    register_bank_sb u_dut (
        .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rs1_value(rs1_value), .rs2_value(rs2_value),
        .reg_write(reg_write), .rd(rd), .rd_value(rd_value), .issue_valid(issue_valid),
        .issue_rd(issue_rd), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .stall(stall),
        .waw_err(waw_err)
    );

    register_bank_sb #(.XLEN(64), .NREGS(16)) u_wide (
        .clk(clk), .rst(rst), .rs1(w_rs1), .rs2(w_rs2), .rs1_value(w_rs1_value),
        .rs2_value(w_rs2_value), .reg_write(w_reg_write), .rd(w_rd), .rd_value(w_rd_value),
        .issue_valid(w_issue_valid), .issue_rd(w_issue_rd), .rs1_busy(w_rs1_busy),
        .rs2_busy(w_rs2_busy), .stall(w_stall), .waw_err(w_waw_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reg_write = 1'b0; issue_valid = 1'b0; rd = '0; issue_rd = '0; rd_value = '0;
    endtask

    task automatic test_reset();
        if (rs1_value !== 32'h0) begin $display("FAIL reset_rs1 got %h want 0", rs1_value); failures++; end
        checks++;
        if ({rs1_busy, rs2_busy, stall, waw_err} !== 4'b0) begin
            $display("FAIL reset_flags got %b want 0000", {rs1_busy, rs2_busy, stall, waw_err}); failures++;
        end
        checks++;
        reg_write = 1'b1; rd = 5'd5; rd_value = 32'hDEADBEEF;
        tick(); idle(); rs1 = 5'd5; #1;
        if (rs1_value !== 32'hDEADBEEF) begin $display("FAIL pre_reset_x5 got %h want deadbeef", rs1_value); failures++; end
        checks++;
        issue_valid = 1'b1; issue_rd = 5'd5;
        tick(); idle(); #1;
        if (rs1_busy !== 1'b1) begin $display("FAIL pre_reset_busy got %b want 1", rs1_busy); failures++; end
        checks++;
        // Would raise waw_err and keep x5 pending without the reset.
        rst = 1'b1; issue_valid = 1'b1; issue_rd = 5'd5; reg_write = 1'b1; rd = 5'd6; rd_value = 32'h66;
        tick(); rst = 1'b0; idle(); rs1 = 5'd5; rs2 = 5'd6; #1;
        if (rs1_value !== 32'h0 || rs2_value !== 32'h0) begin
            $display("FAIL reset_clear got %h/%h want 0/0", rs1_value, rs2_value); failures++;
        end
        checks++;
        if ({rs1_busy, rs2_busy, stall, waw_err} !== 4'b0) begin
            $display("FAIL reset_midop_flags got %b want 0000", {rs1_busy, rs2_busy, stall, waw_err}); failures++;
        end
        checks++;
    endtask

    task automatic test_x0();
        reg_write = 1'b1; rd = 5'd0; rd_value = 32'hFFFFFFFF; issue_valid = 1'b1; issue_rd = 5'd0;
        rs1 = 5'd0; rs2 = 5'd0; #1;
        if (rs1_value !== 32'h0) begin $display("FAIL x0_same_cycle got %h want 0", rs1_value); failures++; end
        checks++;
        tick(); issue_valid = 1'b1; issue_rd = 5'd0; reg_write = 1'b0;
        tick(); idle(); #1;
        if ({rs1_value, rs1_busy, waw_err} !== 34'h0) begin
            $display("FAIL x0_protect got val=%h busy=%b waw=%b want 0/0/0", rs1_value, rs1_busy, waw_err);
            failures++;
        end
        checks++;
    endtask

    task automatic test_scoreboard();
        reg_write = 1'b1; rd = 5'd7; rd_value = 32'hAAAA0007;
        tick(); idle(); issue_valid = 1'b1; issue_rd = 5'd7;
        tick(); idle(); rs1 = 5'd0; rs2 = 5'd7; #1;
        if ({rs2_busy, stall} !== 2'b11 || rs2_value !== 32'hAAAA0007) begin
            $display("FAIL sb_issue got busy=%b stall=%b val=%h want 1/1/aaaa0007", rs2_busy, stall, rs2_value);
            failures++;
        end
        checks++;
        tick(); tick(); reg_write = 1'b1; rd = 5'd7; rd_value = 32'h1234; #1;
`ifdef REGFILE_BYPASS_EN
        if (rs2_value !== 32'h1234 || {rs2_busy, stall} !== 2'b00) begin
            $display("FAIL sb_wb_cycle got val=%h busy=%b stall=%b want 1234/0/0", rs2_value, rs2_busy, stall);
            failures++;
        end
`else
        if (rs2_value !== 32'hAAAA0007 || {rs2_busy, stall} !== 2'b11) begin
            $display("FAIL sb_wb_cycle got val=%h busy=%b stall=%b want aaaa0007/1/1", rs2_value, rs2_busy, stall);
            failures++;
        end
`endif
        checks++;
        tick(); idle(); #1;
        if (rs2_value !== 32'h1234 || {rs2_busy, stall} !== 2'b00) begin
            $display("FAIL sb_after_wb got val=%h busy=%b stall=%b want 1234/0/0", rs2_value, rs2_busy, stall);
            failures++;
        end
        checks++;
    endtask

    task automatic test_same_cycle();
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick(); idle();
        issue_valid = 1'b1; issue_rd = 5'd9; reg_write = 1'b1; rd = 5'd9; rd_value = 32'h9999;
        tick(); idle(); rs1 = 5'd9; #1;
        if ({rs1_busy, waw_err} !== 2'b10 || rs1_value !== 32'h9999) begin
            $display("FAIL same_cycle got busy=%b waw=%b val=%h want 1/0/9999", rs1_busy, waw_err, rs1_value);
            failures++;
        end
        checks++;
        reg_write = 1'b1; rd = 5'd9; rd_value = 32'h99990000;
        tick(); idle(); #1;
        if (rs1_busy !== 1'b0 || rs1_value !== 32'h99990000) begin
            $display("FAIL same_cycle_clear got busy=%b val=%h want 0/99990000", rs1_busy, rs1_value); failures++;
        end
        checks++;
    endtask

    task automatic test_waw();
        issue_valid = 1'b1; issue_rd = 5'd3;
        tick(); idle(); #1;
        if (waw_err !== 1'b0) begin $display("FAIL waw_first_issue got %b want 0", waw_err); failures++; end
        checks++;
        tick(); issue_valid = 1'b1; issue_rd = 5'd3;
        tick(); idle(); rs1 = 5'd3; #1;
        if (waw_err !== 1'b1 || rs1_busy !== 1'b1) begin
            $display("FAIL waw_pulse got waw=%b busy=%b want 1/1", waw_err, rs1_busy); failures++;
        end
        checks++;
        tick(); #1;
        if (waw_err !== 1'b0 || rs1_busy !== 1'b1) begin
            $display("FAIL waw_one_cycle got waw=%b busy=%b want 0/1", waw_err, rs1_busy); failures++;
        end
        checks++;
        reg_write = 1'b1; rd = 5'd3; rd_value = 32'h3;
        tick(); idle(); #1;
        if (rs1_busy !== 1'b0 || rs1_value !== 32'h3) begin
            $display("FAIL waw_clear got busy=%b val=%h want 0/3", rs1_busy, rs1_value); failures++;
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        reg_write = 1'b1; rd = 5'd1; rd_value = 32'h11111111;
        tick(); rd = 5'd2; rd_value = 32'h22222222;
        tick(); rd = 5'd31; rd_value = 32'h80000001;
        tick(); idle(); rs1 = 5'd1; rs2 = 5'd2; #1;
        if (rs1_value !== 32'h11111111 || rs2_value !== 32'h22222222) begin
            $display("FAIL b2b_x1_x2 got %h/%h want 11111111/22222222", rs1_value, rs2_value); failures++;
        end
        checks++;
        rs1 = 5'd31; rs2 = 5'd7; #1;
        if (rs1_value !== 32'h80000001 || rs2_value !== 32'h1234) begin
            $display("FAIL b2b_x31_x7 got %h/%h want 80000001/00001234", rs1_value, rs2_value); failures++;
        end
        checks++;
    endtask

    task automatic test_params();
        w_reg_write = 1'b1; w_rd = 4'd15; w_rd_value = 64'h0123456789ABCDEF;
        tick(); w_rd = 4'd14; w_rd_value = 64'hFEDCBA9876543210;
        tick(); w_reg_write = 1'b0; w_rs1 = 4'd15; w_rs2 = 4'd15; #1;
        if (w_rs1_value !== 64'h0123456789ABCDEF || w_rs2_value !== 64'h0123456789ABCDEF) begin
            $display("FAIL wide_x15 got %h/%h want 0123456789abcdef", w_rs1_value, w_rs2_value); failures++;
        end
        checks++;
        w_rs2 = 4'd14; w_issue_valid = 1'b1; w_issue_rd = 4'd15;
        tick(); w_issue_valid = 1'b0; #1;
        if (w_rs2_value !== 64'hFEDCBA9876543210 || {w_rs1_busy, w_rs2_busy, w_stall} !== 3'b101) begin
            $display("FAIL wide_x14_busy got %h busy=%b%b%b want fedcba9876543210/101", w_rs2_value,
                     w_rs1_busy, w_rs2_busy, w_stall);
            failures++;
        end
        checks++;
    endtask

    initial begin
        rst = 1'b1; idle(); rs1 = '0; rs2 = '0;
        w_rs1 = '0; w_rs2 = '0; w_rd = '0; w_issue_rd = '0; w_rd_value = '0;
        w_reg_write = 1'b0; w_issue_valid = 1'b0;
        tick(); tick(); rst = 1'b0; #1;
        if ({w_rs1_value, w_rs1_busy, w_stall, w_waw_err} !== 67'h0) begin
            $display("FAIL wide_reset got val=%h flags=%b%b%b want 0", w_rs1_value, w_rs1_busy, w_stall,
                     w_waw_err);
            failures++;
        end
        checks++;
        test_reset();
        test_x0();
        test_scoreboard();
        test_same_cycle();
        test_waw();
        test_back_to_back();
        test_params();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_bank_sb.md
# register_bank_sb

Parametrised integer register file with a write-back scoreboard, the successor to the fixed 32x32 register bank in the core's decode stage. It provides two combinational read ports, one write port, and a per-register pending bit that is set at issue and cleared at write-back. It drives operand-hazard stall signals to the pipeline controller and can optionally forward the write-back value to the read ports in the same cycle.

## Interface
Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of registers; must be a power of two, ≥ 2. Derived localparam AW = $clog2(NREGS).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- rs1  input  AW  read port 1 index.
- rs2  input  AW  read port 2 index.
- rs1_value  output  XLEN  read port 1 data.
- rs2_value  output  XLEN  read port 2 data.
- reg_write  input  1  write-back enable.
- rd  input  AW  write-back index.
- rd_value  input  XLEN  write-back data.
- issue_valid  input  1  an instruction writing issue_rd is issued this cycle.
- issue_rd  input  AW  destination of the issued instruction.
- rs1_busy  output  1  rs1 has an outstanding write-back.
- rs2_busy  output  1  rs2 has an outstanding write-back.
- stall  output  1  rs1_busy | rs2_busy.
- waw_err  output  1  registered one-cycle pulse flagging an illegal issue to a pending register.

## Operation
- Storage: NREGS x XLEN array plus an NREGS-bit pending vector.
- Index 0 is hardwired:
  - It reads 0.
  - Writes to it are ignored.
  - Its pending bit is never set.
  - It is never busy.
- Write: on a rising edge with reg_write=1 and rd≠0, regfile[rd] ← rd_value. Clear pending[rd] on the same edge.
- Issue: on a rising edge with issue_valid=1 and issue_rd≠0, set pending[issue_rd].
- Same index in one cycle: if issue_rd == rd (≠0) with both valid, the set wins and pending stays 1 (new producer outstanding).
- Read (combinational):
  - rsN_value = 0 if rsN==0.
  - Otherwise forwarded rd_value when the bypass condition holds (see Configuration).
  - Otherwise regfile[rsN].
- Busy (combinational): rsN_busy = pending[rsN], except masked to 0 when the bypass condition holds.
- WAW check: waw_err is registered. It is 1 in the cycle after an edge where all of the following held: issue_valid=1, issue_rd≠0, pending[issue_rd]=1, and not (reg_write=1 and rd==issue_rd). It is 0 otherwise.
  - The error is reported only. Pending stays set, and upstream must not issue.
- Reset: while rst=1 at a rising edge:
  - All registers are set to 0.
  - All pending bits are cleared.
  - waw_err is cleared.
  - reg_write and issue_valid are ignored.
  - Reset applies mid-operation with no residue.

## Timing
- Read latency: 0 cycles (combinational from rs1/rs2 and array state).
- Write-to-read: without bypass, a write is visible on read ports the cycle after the edge. With bypass, it is visible in the same cycle.
- Issue-to-busy: pending is visible 1 cycle after the issue edge.
- Write-back-to-unbusy: without bypass, 1 cycle after the write edge. With bypass, in the same cycle.
- Reset values: all outputs are 0 after reset.
  - rs*_value = 0, because every register is 0.
  - rs*_busy = 0, stall = 0, waw_err = 0.
- No handshake back-pressure. stall is advisory to the controller; the block never blocks a write.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined: the bypass condition is (reg_write=1 and rd==rsN and rd≠0).
  - rsN_value = rd_value in that cycle.
  - rsN_busy is forced to 0 in that cycle.
- Undefined: the bypass condition is never true.
  - Reads return array contents only.
  - Busy reflects the pending bit only.
  - A reader of a register being written this cycle sees the old value and busy=1 (if pending).

## Test plan
- Reset: write x5=0xDEADBEEF, assert rst one cycle → rs1=5 reads 0x0. All busy/stall/waw_err = 0.
- x0 protection: reg_write=1, rd=0, rd_value=0xFFFFFFFF; issue_valid=1, issue_rd=0 → rs1=0 reads 0, rs1_busy=0, no waw_err.
- Scoreboard: issue x7 at cycle n → rs2=7 busy=1 and stall=1 from n+1. At cycle n+3, write x7=0x1234:
  - Without REGFILE_BYPASS_EN: busy=1 and value=old in n+3; value=0x1234 and busy=0 in n+4.
  - With REGFILE_BYPASS_EN: value=0x1234 and busy=0 in n+3.
- Simultaneous issue and write-back to x9, while x9 is pending → pending stays 1, waw_err=0, array holds the written value next cycle.
- WAW: issue x3, then issue x3 again two cycles later with no write-back → waw_err=1 for exactly one cycle after the second issue edge.
- Parameters: XLEN=64, NREGS=16 → write 0x0123456789ABCDEF to x15, read back on both ports; index width 4.
